// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter and its FIFO.
// The write-port grant encoding is shared so every consumer agrees on the priority order.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    GNT_IDLE   = 2'd0,
    GNT_ALU    = 2'd1,
    GNT_FIFO   = 2'd2,
    GNT_BYPASS = 2'd3
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers are PW bits wide and DEPTH is a power of 2, so they wrap on their own.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; entries are only observable once count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: muxes ALU and long-latency results onto the register file write port
// and tracks in-flight long-latency destinations in a per-register busy scoreboard.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = wb_arbiter_pkg::XLEN
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                alu_wen_i,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0] alu_waddr_i,
  input  logic [XLEN-1:0]                     alu_wdata_i,
  input  logic                                lsu_valid_i,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0] lsu_waddr_i,
  input  logic [XLEN-1:0]                     lsu_wdata_i,
  output logic                                lsu_ready_o,
  input  logic                                issue_i,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0] issue_rd_i,
  output logic [wb_arbiter_pkg::NUM_REGS-1:0]   busy_o,
  output logic [wb_arbiter_pkg::REG_ADDR_W-1:0] reg_waddr_o,
  output logic [XLEN-1:0]                     reg_wdata_o,
  output logic                                reg_wen_o
);

  import wb_arbiter_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = REG_ADDR_W + XLEN;

  grant_e                grant;
  logic                  alu_ok;
  logic                  accept;
  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [EW-1:0]         fifo_rdata;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic                  fifo_full_unused;
  logic                  lsu_wr;
  logic [REG_ADDR_W-1:0] lsu_wr_addr;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  ({lsu_waddr_i, lsu_wdata_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign fifo_full_unused       = fifo_full;
  assign {head_addr, head_data} = fifo_rdata;

  // Ready depends only on registered occupancy, never on lsu_valid_i.
  assign lsu_ready_o = rst && (fifo_count < CW'(DEPTH));
  assign alu_ok      = alu_wen_i && (alu_waddr_i != '0);
  assign accept      = lsu_valid_i && lsu_ready_o;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = GNT_IDLE;
    if (rst) begin
      if (alu_ok)           grant = GNT_ALU;
      else if (!fifo_empty) grant = GNT_FIFO;
      else if (lsu_valid_i) grant = GNT_BYPASS;
    end
  end

  assign fifo_pop  = (grant == GNT_FIFO);
  assign fifo_push = accept && (grant != GNT_BYPASS);

  // Long-latency results to x0 still consume their grant but leave the port idle.
  always_comb begin
    lsu_wr      = 1'b0;
    lsu_wr_addr = '0;
    reg_wen_o   = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    case (grant)
      GNT_ALU: begin
        reg_wen_o   = 1'b1;
        reg_waddr_o = alu_waddr_i;
        reg_wdata_o = alu_wdata_i;
      end
      GNT_FIFO: begin
        lsu_wr_addr = head_addr;
        if (head_addr != '0) begin
          lsu_wr      = 1'b1;
          reg_wen_o   = 1'b1;
          reg_waddr_o = head_addr;
          reg_wdata_o = head_data;
        end
      end
      GNT_BYPASS: begin
        lsu_wr_addr = lsu_waddr_i;
        if (lsu_waddr_i != '0) begin
          lsu_wr      = 1'b1;
          reg_wen_o   = 1'b1;
          reg_waddr_o = lsu_waddr_i;
          reg_wdata_o = lsu_wdata_i;
        end
      end
      default: ;
    endcase
  end

  // Clear is applied before set so a same-cycle issue to the committing register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (lsu_wr)                          busy_d[lsu_wr_addr] = 1'b0;
    if (issue_i && (issue_rd_i != '0))   busy_d[issue_rd_i]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a table of single-cycle vectors with the FIFO empty,
// followed by hand-written multi-cycle sequences for ordering, scoreboard, x0 and reset.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_wen_i;
  logic [4:0]  alu_waddr_i;
  logic [31:0] alu_wdata_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] busy_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wen_o;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_wen_i   (alu_wen_i),
    .alu_waddr_i (alu_waddr_i),
    .alu_wdata_i (alu_wdata_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_ready_o (lsu_ready_o),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .busy_o      (busy_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wen_o   (reg_wen_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_wen;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample outputs mid-cycle, well away from either edge used for driving.
  task automatic settle();
    #4;
  endtask

  task automatic drive(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_wen_i   = aw;
    alu_waddr_i = aa;
    alu_wdata_i = ad;
    lsu_valid_i = lv;
    lsu_waddr_i = la;
    lsu_wdata_i = ld;
  endtask

  task automatic expect_port(input string name, input logic wen, input logic [4:0] addr,
                             input logic [31:0] data);
    check({name, ".wen"},   {31'd0, reg_wen_o},   {31'd0, wen});
    check({name, ".waddr"}, {27'd0, reg_waddr_o}, {27'd0, addr});
    check({name, ".wdata"}, reg_wdata_o,          data);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1};
    vecs[3] = '{1'b1, 5'd1,  32'h00001234, 1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  32'h00001234, 1'b1};
    vecs[4] = '{1'b1, 5'd0,  32'h00000055, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1};
    vecs[5] = '{1'b1, 5'd0,  32'h00000099, 1'b1, 5'd12, 32'h0000CAFE, 1'b1, 5'd12, 32'h0000CAFE, 1'b1};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00000077, 1'b0, 5'd0,  32'h0,        1'b1};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1};

    // Reset held with every input active.
    rst        = 1'b0;
    issue_i    = 1'b1;
    issue_rd_i = 5'd3;
    drive(1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222);
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("rst.wen",   {31'd0, reg_wen_o},   32'd0);
      check("rst.ready", {31'd0, lsu_ready_o}, 32'd0);
      check("rst.busy",  busy_o,               32'd0);
    end
    step();
    rst     = 1'b1;
    issue_i = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    check("post_rst.ready", {31'd0, lsu_ready_o}, 32'd1);
    check("post_rst.busy",  busy_o,               32'd0);

    // Single-cycle vectors, FIFO stays empty throughout.
    for (int i = 0; i < 9; i++) begin
      step();
      drive(vecs[i].alu_wen, vecs[i].alu_waddr, vecs[i].alu_wdata,
            vecs[i].lsu_valid, vecs[i].lsu_waddr, vecs[i].lsu_wdata);
      settle();
      expect_port($sformatf("vec%0d", i), vecs[i].exp_wen, vecs[i].exp_waddr, vecs[i].exp_wdata);
      check($sformatf("vec%0d.ready", i), {31'd0, lsu_ready_o}, {31'd0, vecs[i].exp_ready});
    end

    // Conflict and ordering: ALU owns the port for four cycles, two results queue up,
    // a third is held off while full and then pushed in the same cycle as a pop.
    step(); drive(1'b1, 5'd1, 32'hA0, 1'b1, 5'd7, 32'h11); settle();
    expect_port("ord.c0", 1'b1, 5'd1, 32'hA0);
    check("ord.c0.ready", {31'd0, lsu_ready_o}, 32'd1);
    step(); drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd8, 32'h22); settle();
    expect_port("ord.c1", 1'b1, 5'd1, 32'hA1);
    check("ord.c1.ready", {31'd0, lsu_ready_o}, 32'd1);
    step(); drive(1'b1, 5'd1, 32'hA2, 1'b1, 5'd9, 32'h33); settle();
    expect_port("ord.c2", 1'b1, 5'd1, 32'hA2);
    check("ord.c2.ready", {31'd0, lsu_ready_o}, 32'd0);
    step(); drive(1'b1, 5'd1, 32'hA3, 1'b1, 5'd9, 32'h33); settle();
    expect_port("ord.c3", 1'b1, 5'd1, 32'hA3);
    check("ord.c3.ready", {31'd0, lsu_ready_o}, 32'd0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h33); settle();
    expect_port("ord.c4", 1'b1, 5'd7, 32'h11);
    check("ord.c4.ready", {31'd0, lsu_ready_o}, 32'd0);
    step(); settle();
    expect_port("ord.c5", 1'b1, 5'd8, 32'h22);
    check("ord.c5.ready", {31'd0, lsu_ready_o}, 32'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); settle();
    expect_port("ord.c6", 1'b1, 5'd9, 32'h33);
    step(); settle();
    expect_port("ord.c7", 1'b0, 5'd0, 32'h0);

    // Scoreboard set, clear after commit, and set-wins on a same-cycle collision.
    step(); issue_i = 1'b1; issue_rd_i = 5'd9; settle();
    step(); issue_i = 1'b0; settle();
    check("sb.set", {31'd0, busy_o[9]}, 32'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99); settle();
    check("sb.hold_during_wr", {31'd0, busy_o[9]}, 32'd1);
    expect_port("sb.wr", 1'b1, 5'd9, 32'h99);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); settle();
    check("sb.clear", {31'd0, busy_o[9]}, 32'd0);
    step(); issue_i = 1'b1; issue_rd_i = 5'd9; settle();
    step(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h98); settle();
    check("sb.busy_before_collide", {31'd0, busy_o[9]}, 32'd1);
    step(); issue_i = 1'b0; drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); settle();
    check("sb.set_wins", {31'd0, busy_o[9]}, 32'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h97); settle();
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); issue_i = 1'b1; issue_rd_i = 5'd0; settle();
    check("sb.cleared_again", busy_o, 32'd0);
    step(); issue_i = 1'b0; settle();
    check("sb.x0_never_busy", busy_o, 32'd0);

    // x0: dropped ALU write lets the FIFO head drain; an x0 result pops silently.
    step(); drive(1'b1, 5'd1, 32'hB0, 1'b1, 5'd3, 32'h5); settle();
    expect_port("x0.c0", 1'b1, 5'd1, 32'hB0);
    step(); drive(1'b1, 5'd0, 32'hB1, 1'b0, 5'd0, 32'h0); settle();
    expect_port("x0.alu_x0_head", 1'b1, 5'd3, 32'h5);
    step(); drive(1'b1, 5'd1, 32'hB2, 1'b1, 5'd0, 32'h66); settle();
    step(); drive(1'b1, 5'd1, 32'hB3, 1'b1, 5'd4, 32'h44); settle();
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); settle();
    expect_port("x0.lsu_x0_pop", 1'b0, 5'd0, 32'h0);
    step(); settle();
    expect_port("x0.after_pop", 1'b1, 5'd4, 32'h44);
    step(); settle();
    expect_port("x0.drained", 1'b0, 5'd0, 32'h0);

    // Reset mid-stream with two entries buffered and one register busy.
    step(); drive(1'b1, 5'd1, 32'hC0, 1'b1, 5'd10, 32'hA); issue_i = 1'b1; issue_rd_i = 5'd10; settle();
    step(); drive(1'b1, 5'd1, 32'hC1, 1'b1, 5'd11, 32'hB); issue_i = 1'b0; settle();
    check("mid.busy_before", {31'd0, busy_o[10]}, 32'd1);
    check("mid.full", {31'd0, lsu_ready_o}, 32'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); rst = 1'b0; settle();
    check("mid.rst_wen",   {31'd0, reg_wen_o},   32'd0);
    check("mid.rst_ready", {31'd0, lsu_ready_o}, 32'd0);
    step(); rst = 1'b1; settle();
    expect_port("mid.after0", 1'b0, 5'd0, 32'h0);
    check("mid.busy_after", busy_o, 32'd0);
    check("mid.ready_after", {31'd0, lsu_ready_o}, 32'd1);
    step(); settle();
    expect_port("mid.after1", 1'b0, 5'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
